// File: rtl/time_of_day_counter.sv
`default_nettype none
// ============================================================================
// Module      : time_of_day_counter
// Description : BCD HH:MM:SS time-of-day counter advanced by a clk-synchronous
//               1 s square wave, with load/validate, run/hold and strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module time_of_day_counter #(
  parameter int HOUR_MODULO = 24,
  parameter int BOTH_EDGES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_in,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic       sec_pulse,
  output logic       min_rollover,
  output logic       day_rollover,
  output logic       load_err
);

  localparam int         c_HH_LAST     = HOUR_MODULO - 1;
  localparam logic [7:0] c_HH_LAST_BCD = {4'(c_HH_LAST / 10), 4'(c_HH_LAST % 10)};
  localparam logic [7:0] c_HOUR_MOD    = 8'(HOUR_MODULO);

  logic       r_sec_d;
  logic       r_armed;
  logic [7:0] r_hh;
  logic [7:0] r_mm;
  logic [7:0] r_ss;
  logic       r_sec_pulse;
  logic       r_min_rollover;
  logic       r_day_rollover;
  logic       r_load_err;

  logic       w_edge;
  logic       w_tick;
  logic [7:0] w_hh_dec;
  logic       w_digits_ok;
  logic       w_load_ok;
  logic       w_ss_wrap;
  logic       w_mm_wrap;
  logic       w_hh_wrap;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  generate
    if (BOTH_EDGES != 0) begin : g_both_edges
      assign w_edge = sec_in ^ r_sec_d;
    end else begin : g_rising_edge
      assign w_edge = sec_in & ~r_sec_d;
    end
  endgenerate

  // armed stays low for the first cycle out of reset so a high sec_in is not a tick
  assign w_tick = r_armed & w_edge;

  // hours tens*10 + units built from shifts to stay in BCD-only datapath
  assign w_hh_dec = {1'b0, load_hh[7:4], 3'b000}
                  + {3'b000, load_hh[7:4], 1'b0}
                  + {4'b0000, load_hh[3:0]};

  assign w_digits_ok = (load_hh[7:4] <= 4'd9) && (load_hh[3:0] <= 4'd9) &&
                       (load_mm[7:4] <= 4'd9) && (load_mm[3:0] <= 4'd9) &&
                       (load_ss[7:4] <= 4'd9) && (load_ss[3:0] <= 4'd9);

  assign w_load_ok = w_digits_ok &&
                     (load_ss[7:4] <= 4'd5) &&
                     (load_mm[7:4] <= 4'd5) &&
                     (w_hh_dec < c_HOUR_MOD);

  assign w_ss_wrap = (r_ss == 8'h59);
  assign w_mm_wrap = (r_mm == 8'h59);
  assign w_hh_wrap = (r_hh == c_HH_LAST_BCD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_d        <= 1'b0;
      r_armed        <= 1'b0;
      r_hh           <= 8'h00;
      r_mm           <= 8'h00;
      r_ss           <= 8'h00;
      r_sec_pulse    <= 1'b0;
      r_min_rollover <= 1'b0;
      r_day_rollover <= 1'b0;
      r_load_err     <= 1'b0;
    end else begin
      r_sec_d        <= sec_in;
      r_armed        <= 1'b1;
      r_sec_pulse    <= 1'b0;
      r_min_rollover <= 1'b0;
      r_day_rollover <= 1'b0;
      r_load_err     <= 1'b0;
      // load wins; a coincident tick is consumed and lost
      if (load) begin
        if (w_load_ok) begin
          r_hh <= load_hh;
          r_mm <= load_mm;
          r_ss <= load_ss;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (w_tick && run) begin
        r_sec_pulse <= 1'b1;
        r_ss        <= w_ss_wrap ? 8'h00 : bcd_inc(r_ss);
        if (w_ss_wrap) begin
          r_min_rollover <= 1'b1;
          r_mm           <= w_mm_wrap ? 8'h00 : bcd_inc(r_mm);
          if (w_mm_wrap) begin
            r_hh           <= w_hh_wrap ? 8'h00 : bcd_inc(r_hh);
            r_day_rollover <= w_hh_wrap;
          end
        end
      end
    end
  end

  assign hh_bcd       = r_hh;
  assign mm_bcd       = r_mm;
  assign ss_bcd       = r_ss;
  assign sec_pulse    = r_sec_pulse;
  assign min_rollover = r_min_rollover;
  assign day_rollover = r_day_rollover;
  assign load_err     = r_load_err;

endmodule
`default_nettype wire
